io_select_sequencer: RTL and testbench

IO_SELECT_SEQUENCER -- requirements
Module: io_select_sequencer

---
 rtl/io_select_sequencer.sv | 103 ++++++++++
 tb/tb_io_select_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/io_select_sequencer.sv
// One-hot IO select sequencer: drives 1<<addr onto a tristate bus
// for HOLD cycles per explicit request or round-robin scan.
module io_select_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int N_PORTS = 16,
  parameter int HOLD    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  input  logic               scan_en,
  output tri   [N_PORTS-1:0] d_addr,
  output logic [ADDR_W-1:0]  cur_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);
  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RELEASE
  } state_t;

  localparam logic [ADDR_W:0]   NP     = (ADDR_W+1)'(N_PORTS);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N_PORTS-1);
  localparam logic [3:0]        RELOAD = 4'(HOLD-1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]  scan_ptr_q, scan_ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [N_PORTS-1:0] sel;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    scan_ptr_d = scan_ptr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // An explicit request wins over a scan and freezes scan_ptr
        if (req) begin
          if ({1'b0, req_addr} >= NP) begin
            err_d = 1'b1;
          end else begin
            state_d    = DRIVE;
            cur_addr_d = req_addr;
            cnt_d      = RELOAD;
          end
        end else if (scan_en) begin
          state_d    = DRIVE;
          cur_addr_d = scan_ptr_q;
          cnt_d      = RELOAD;
          scan_ptr_d = (scan_ptr_q == LAST) ? '0
                     : scan_ptr_q + ADDR_W'(1);
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_d = RELEASE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      scan_ptr_q <= '0;
      cnt_q      <= 4'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      scan_ptr_q <= scan_ptr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sel       = N_PORTS'(1) << cur_addr_q;
  assign d_addr    = (state_q == DRIVE) ? sel : 'z;
  assign req_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign cur_addr  = cur_addr_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_io_select_sequencer.sv
// Directed bench for io_select_sequencer: default, N_PORTS=10
// and N_PORTS=3 instances sharing clock and reset.
module tb_io_select_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r0 = 0, s0 = 0, rdy0, busy0, done0, err0;
  logic [3:0]  a0 = 0, cur0;
  wire  [15:0] d0;
  logic        r1 = 0, s1 = 0, rdy1, busy1, done1, err1;
  logic [3:0]  a1 = 0, cur1;
  wire  [9:0]  d1;
  logic        r2 = 0, s2 = 0, rdy2, busy2, done2, err2;
  logic [3:0]  a2 = 0, cur2;
  wire  [2:0]  d2;

  io_select_sequencer dut0 (
    .clk(clk), .rst(rst), .req(r0), .req_addr(a0),
    .req_ready(rdy0), .scan_en(s0), .d_addr(d0),
    .cur_addr(cur0), .busy(busy0), .done(done0), .err(err0)
  );
  io_select_sequencer #(.N_PORTS(10)) dut1 (
    .clk(clk), .rst(rst), .req(r1), .req_addr(a1),
    .req_ready(rdy1), .scan_en(s1), .d_addr(d1),
    .cur_addr(cur1), .busy(busy1), .done(done1), .err(err1)
  );
  io_select_sequencer #(.N_PORTS(3)) dut2 (
    .clk(clk), .rst(rst), .req(r2), .req_addr(a2),
    .req_ready(rdy2), .scan_en(s2), .d_addr(d2),
    .cur_addr(cur2), .busy(busy2), .done(done2), .err(err2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Released bus reads as Z (4-state) or 0 (2-state)
  function automatic logic [31:0] off16(input logic [15:0] v);
    return 32'((v === 16'hzzzz) || (v === 16'h0000));
  endfunction
  function automatic logic [31:0] off10(input logic [9:0] v);
    return 32'((v === 10'hzzz) || (v === 10'h000));
  endfunction
  function automatic logic [31:0] off3(input logic [2:0] v);
    return 32'((v === 3'bzzz) || (v === 3'b000));
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [2:0] e3;
    tick();
    chk("rst_ready", 32'(rdy0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_cur", 32'(cur0), 0);
    chk("rst_bus", off16(d0), 1);
    rst = 0;
    #1;
    chk("ready_after_rst", 32'(rdy0), 1);

    // single request, addr 5
    r0 = 1; a0 = 5;
    tick(); r0 = 0;
    chk("single_c1_bus", 32'(d0), 32'h0020);
    chk("single_c1_busy", 32'(busy0), 1);
    chk("single_c1_ready", 32'(rdy0), 0);
    chk("single_c1_cur", 32'(cur0), 5);
    tick();
    chk("single_c2_bus", 32'(d0), 32'h0020);
    chk("single_c2_done", 32'(done0), 0);
    tick();
    chk("single_c3_bus", off16(d0), 1);
    chk("single_c3_done", 32'(done0), 1);
    chk("single_c3_busy", 32'(busy0), 1);
    tick();
    chk("single_c4_ready", 32'(rdy0), 1);
    chk("single_c4_done", 32'(done0), 0);
    chk("single_c4_busy", 32'(busy0), 0);

    // request during DRIVE with another address is ignored
    r0 = 1; a0 = 3;
    tick();
    a0 = 9;
    chk("ign_c1_bus", 32'(d0), 32'h0008);
    tick();
    chk("ign_c2_bus", 32'(d0), 32'h0008);
    chk("ign_c2_cur", 32'(cur0), 3);
    tick();
    chk("ign_c3_done", 32'(done0), 1);
    chk("ign_c3_cur", 32'(cur0), 3);
    r0 = 0;
    tick();
    chk("ign_c4_cur", 32'(cur0), 3);
    chk("ign_c4_busy", 32'(busy0), 0);

    // two scans, then request beats scan at scan_ptr=2
    s0 = 1;
    tick();
    chk("scan0_bus", 32'(d0), 32'h0001);
    tick(4);
    chk("scan1_bus", 32'(d0), 32'h0002);
    s0 = 0;
    tick(3);
    chk("prio_idle_ready", 32'(rdy0), 1);
    r0 = 1; a0 = 7; s0 = 1;
    tick();
    r0 = 0; s0 = 0;
    chk("prio_bus", 32'(d0), 32'h0080);
    chk("prio_cur", 32'(cur0), 7);
    tick(3);
    s0 = 1;
    tick();
    s0 = 0;
    chk("prio_next_scan", 32'(d0), 32'h0004);
    tick(3);

    // N_PORTS=10: highest legal address then out-of-range
    r1 = 1; a1 = 9;
    tick(); r1 = 0;
    chk("n10_max_bus", 32'(d1), 32'h200);
    tick(3);
    r1 = 1; a1 = 12;
    tick(); r1 = 0;
    chk("n10_err", 32'(err1), 1);
    chk("n10_err_busy", 32'(busy1), 0);
    chk("n10_err_cur", 32'(cur1), 9);
    chk("n10_err_bus", off10(d1), 1);
    tick();
    chk("n10_err_pulse", 32'(err1), 0);
    r1 = 1; a1 = 10;
    tick(); r1 = 0;
    chk("n10_edge_err", 32'(err1), 1);
    chk("n10_edge_bus", off10(d1), 1);

    // N_PORTS=3: continuous scan wraps 0,1,2,0
    s2 = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e3 = 3'(3'b001 << (((k - 1) / 4) % 3));
      if ((k - 1) % 4 < 2)
        chk($sformatf("n3_scan_c%0d", k), 32'(d2), 32'(e3));
      else
        chk($sformatf("n3_scan_off_c%0d", k), off3(d2), 1);
      if ((k - 1) % 4 == 2)
        chk($sformatf("n3_done_c%0d", k), 32'(done2), 1);
      chk($sformatf("n3_err_c%0d", k), 32'(err2), 0);
    end
    s2 = 0;
    tick(4);

    // reset in first DRIVE cycle
    r0 = 1; a0 = 4;
    tick(); r0 = 0;
    chk("rstd_c1_bus", 32'(d0), 32'h0010);
    rst = 1;
    tick();
    chk("rstd_bus", off16(d0), 1);
    chk("rstd_done", 32'(done0), 0);
    chk("rstd_busy", 32'(busy0), 0);
    chk("rstd_cur", 32'(cur0), 0);
    chk("rstd_ready_in_rst", 32'(rdy0), 0);
    rst = 0;
    #1;
    chk("rstd_ready", 32'(rdy0), 1);
    tick();
    chk("rstd_no_done", 32'(done0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
